// File: rtl/params_noc.sv
// rtl/params_noc.sv - shared NoC flit, label and link-transmitter state types
package params_noc;

   localparam int FLIT_DATA_WIDTH = 32;

   // Position of a flit inside its packet
   typedef enum logic [1:0] {
      HEAD     = 2'b00,
      BODY     = 2'b01,
      TAIL     = 2'b10,
      HEADTAIL = 2'b11
   } flit_label_t;

   // Flit as carried on a link without virtual channels
   typedef struct packed {
      flit_label_t                flit_label;
      logic [FLIT_DATA_WIDTH-1:0] data;
   } flit_Data_noVC;

   // Packet-framing state of the link transmitter
   typedef enum logic {
      IDLE   = 1'b0,
      PACKET = 1'b1
   } tx_state_t;

endpackage

// File: rtl/noc_credit_counter.sv
// rtl/noc_credit_counter.sv - downstream buffer credit mirror with ready and overflow detect
module noc_credit_counter #(
   parameter int BUFFER_SIZE = 8
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               accept,
   input  logic                               credit_i,
   output logic [$clog2(BUFFER_SIZE+1)-1:0]   credits,
   output logic                               ready,
   output logic                               overflow
);

   localparam int CW = $clog2(BUFFER_SIZE + 1);
   localparam logic [CW-1:0] FULL = CW'(BUFFER_SIZE);

   // Ready depends on the stored count only, so it never loops through the crossbar valid
   assign ready = (credits != '0);

   // A returned credit with the mirror already full means the downstream side lied
   assign overflow = credit_i && !accept && (credits == FULL);

   // Count tracks free downstream slots; accept and credit in the same cycle cancel out
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credits <= FULL;
      end else if (!overflow) begin
         credits <= credits - CW'(accept) + CW'(credit_i);
      end
   end

endmodule

// File: rtl/noc_link_tx.sv
// rtl/noc_link_tx.sv - credit-based NoC link transmitter with packet-framing check
module noc_link_tx
   import params_noc::*;
#(
   parameter int BUFFER_SIZE = 8
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               flit_valid_i,
   input  flit_Data_noVC                      flit_i,
   output logic                               flit_ready_o,
   input  logic                               credit_i,
   output logic                               link_valid_o,
   output flit_Data_noVC                      link_flit_o,
   output logic [$clog2(BUFFER_SIZE+1)-1:0]   credits_o,
   output logic                               in_packet_o,
   output logic                               err_o
);

   logic      accept;
   logic      overflow;
   logic      proto_err;
   tx_state_t state_q;
   tx_state_t state_d;

   assign accept      = flit_valid_i && flit_ready_o;
   assign in_packet_o = (state_q == PACKET);

   noc_credit_counter #(
      .BUFFER_SIZE (BUFFER_SIZE)
   ) u_credit_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .accept   (accept),
      .credit_i (credit_i),
      .credits  (credits_o),
      .ready    (flit_ready_o),
      .overflow (overflow)
   );

   // Framing state register, moves only when a flit is actually launched
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state follows the flit label; out-of-order labels are flagged but still forwarded
   always_comb begin
      state_d   = state_q;
      proto_err = 1'b0;
      if (accept) begin
         case (flit_i.flit_label)
            HEAD: begin
               state_d   = PACKET;
               proto_err = (state_q == PACKET);
            end
            BODY: begin
               state_d   = PACKET;
               proto_err = (state_q == IDLE);
            end
            TAIL: begin
               state_d   = IDLE;
               proto_err = (state_q == IDLE);
            end
            HEADTAIL: begin
               state_d   = IDLE;
               proto_err = (state_q == PACKET);
            end
            default: begin
               state_d   = state_q;
               proto_err = 1'b0;
            end
         endcase
      end
   end

   // Link register: one-cycle launch, flit holds when idle so the wire stays quiet
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         link_valid_o <= 1'b0;
         link_flit_o  <= '0;
      end else begin
         link_valid_o <= accept;
         if (accept) begin
            link_flit_o <= flit_i;
         end
      end
   end

   // Sticky error, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_o <= 1'b0;
      end else if (overflow || proto_err) begin
         err_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_noc_link_tx.sv
// tb/tb_noc_link_tx.sv - self-checking bench for noc_link_tx against a behavioural model
module tb_noc_link_tx;
   import params_noc::*;

   localparam int BS = 8;
   localparam int CW = $clog2(BS + 1);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flit_valid;
   flit_Data_noVC flit;
   logic          flit_ready;
   logic          credit;
   logic          link_valid;
   flit_Data_noVC link_flit;
   logic [CW-1:0] credits;
   logic          in_packet;
   logic          err;

   int n_checks = 0;
   int n_pass   = 0;
   bit cmp_en   = 1'b0;

   noc_link_tx #(.BUFFER_SIZE(BS)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flit_valid_i (flit_valid),
      .flit_i       (flit),
      .flit_ready_o (flit_ready),
      .credit_i     (credit),
      .link_valid_o (link_valid),
      .link_flit_o  (link_flit),
      .credits_o    (credits),
      .in_packet_o  (in_packet),
      .err_o        (err)
   );

   always #5 clk = ~clk;

   // Behavioural model: count of flits occupying the downstream buffer, packet flag, sticky error
   int            m_out;
   bit            m_pkt;
   bit            m_err;
   bit            m_lv;
   flit_Data_noVC m_lf;
   bit            m_acc;
   bit            m_cont;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_out = 0;
         m_pkt = 1'b0;
         m_err = 1'b0;
         m_lv  = 1'b0;
         m_lf  = '0;
      end else begin
         m_acc = flit_valid && (m_out < BS);
         if (m_acc) begin
            m_cont = (flit.flit_label == BODY) || (flit.flit_label == TAIL);
            if (m_pkt != m_cont) m_err = 1'b1;
            m_pkt = (flit.flit_label == HEAD) || (flit.flit_label == BODY);
            m_lf  = flit;
            m_out = m_out + 1;
         end
         m_lv = m_acc;
         if (credit) begin
            if (m_out > 0) m_out = m_out - 1;
            else m_err = 1'b1;
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
   endtask

   // Cycle-by-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (cmp_en) begin
         check("cmp_link_valid", 64'(link_valid), 64'(m_lv));
         check("cmp_link_flit",  64'(link_flit),  64'(m_lf));
         check("cmp_credits",    64'(credits),    64'(BS - m_out));
         check("cmp_ready",      64'(flit_ready), 64'(m_out < BS));
         check("cmp_in_packet",  64'(in_packet),  64'(m_pkt));
         check("cmp_err",        64'(err),        64'(m_err));
      end
   end

   function automatic flit_Data_noVC mk(input flit_label_t l);
      flit_Data_noVC f;
      f.flit_label = l;
      f.data       = $urandom;
      return f;
   endfunction

   // Present inputs for one rising edge, return 1 time unit after it
   task automatic drive(input bit v, input flit_Data_noVC f, input bit c);
      flit_valid = v;
      flit       = f;
      credit     = c;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      flit_valid = 1'b0;
      credit     = 1'b0;
      rst_n      = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
      $fatal(1);
   end

   flit_Data_noVC f9;
   flit_Data_noVC fa;
   flit_Data_noVC fb;

   initial begin
      rst_n      = 1'b1;
      flit_valid = 1'b0;
      credit     = 1'b0;
      flit       = '0;
      #2;
      rst_n = 1'b0;
      #1;
      // Reset values, hand-pinned
      check("rst_link_valid", 64'(link_valid), 64'd0);
      check("rst_link_flit",  64'(link_flit),  64'd0);
      check("rst_credits",    64'(credits),    64'd8);
      check("rst_ready",      64'(flit_ready), 64'd1);
      check("rst_in_packet",  64'(in_packet),  64'd0);
      check("rst_err",        64'(err),        64'd0);
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      cmp_en = 1'b1;

      // Packet with a credit returned every cycle
      drive(1, mk(HEAD), 1);
      check("t1_valid_after_head", 64'(link_valid), 64'd1);
      check("t1_inpkt_after_head", 64'(in_packet), 64'd1);
      drive(1, mk(BODY), 1);
      drive(1, mk(BODY), 1);
      fa = mk(TAIL);
      drive(1, fa, 1);
      check("t1_tail_flit",   64'(link_flit), 64'(fa));
      check("t1_inpkt_tail",  64'(in_packet), 64'd0);
      check("t1_credits",     64'(credits), 64'd8);
      drive(0, mk(HEAD), 0);
      check("t1_valid_drop",  64'(link_valid), 64'd0);
      check("t1_err",         64'(err), 64'd0);

      // Exhaust credits, hold the ninth flit, release with one credit
      do_reset();
      for (int i = 0; i < BS; i++) drive(1, mk(HEADTAIL), 0);
      check("t2_credits_zero", 64'(credits), 64'd0);
      check("t2_ready_low",    64'(flit_ready), 64'd0);
      f9 = mk(HEADTAIL);
      drive(1, f9, 0);
      check("t2_ninth_held",   64'(link_valid), 64'd0);
      drive(1, f9, 1);
      check("t2_credit_in",    64'(credits), 64'd1);
      check("t2_no_accept",    64'(link_valid), 64'd0);
      drive(1, f9, 0);
      check("t2_ninth_sent",   64'(link_valid), 64'd1);
      check("t2_ninth_flit",   64'(link_flit), 64'(f9));
      check("t2_credits_back", 64'(credits), 64'd0);

      // Credit and valid together at zero credits, then accept plus credit
      fb = mk(HEADTAIL);
      drive(1, fb, 1);
      check("t3_credits_one",  64'(credits), 64'd1);
      check("t3_no_accept",    64'(link_valid), 64'd0);
      drive(1, fb, 1);
      check("t3_accept",       64'(link_valid), 64'd1);
      check("t3_credits_hold", 64'(credits), 64'd1);
      check("t3_err",          64'(err), 64'd0);

      // Credit overflow is sticky until reset
      do_reset();
      drive(0, mk(HEAD), 1);
      check("t4_credits_sat",  64'(credits), 64'd8);
      check("t4_err_set",      64'(err), 64'd1);
      for (int i = 0; i < 3; i++) drive(0, mk(HEAD), 0);
      check("t4_err_sticky",   64'(err), 64'd1);
      do_reset();
      check("t4_err_cleared",  64'(err), 64'd0);

      // Framing violations are forwarded and flagged
      fa = mk(BODY);
      drive(1, fa, 0);
      check("t5_body_flit",    64'(link_flit), 64'(fa));
      check("t5_body_err",     64'(err), 64'd1);
      do_reset();
      drive(1, mk(HEAD), 0);
      fb = mk(HEAD);
      drive(1, fb, 0);
      check("t5_head_flit",    64'(link_flit), 64'(fb));
      check("t5_head_valid",   64'(link_valid), 64'd1);
      check("t5_head_err",     64'(err), 64'd1);

      // Asynchronous reset mid-packet with three credits left
      do_reset();
      drive(1, mk(HEAD), 0);
      for (int i = 0; i < 4; i++) drive(1, mk(BODY), 0);
      check("t6_credits_pre",  64'(credits), 64'd3);
      flit_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_credits",      64'(credits), 64'd8);
      check("t6_link_valid",   64'(link_valid), 64'd0);
      check("t6_link_flit",    64'(link_flit), 64'd0);
      check("t6_in_packet",    64'(in_packet), 64'd0);
      check("t6_ready",        64'(flit_ready), 64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) do_reset();
         drive(($urandom_range(0, 3) != 0), mk(flit_label_t'($urandom_range(0, 3))),
               ($urandom_range(0, 1) == 1));
      end

      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
